// File: rtl/pic_rst_pkg.sv
// pic_rst_pkg: state encodings, default phase lengths and counter-width helper
// shared by the reset sequencer and its timer.
package pic_rst_pkg;
  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] OST  = 3'd1;
  localparam logic [2:0] PWRT = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] WDT  = 3'd4;
  localparam int OST_CYCLES_DEF      = 1024;
  localparam int PWRT_CYCLES_DEF     = 4096;
  localparam int WDT_HOLD_CYCLES_DEF = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/pic_rst_timer.sv
// pic_rst_timer: W-bit up-counter with synchronous clear and terminal-count flag,
// shared by every timed phase of the reset sequencer.
module pic_rst_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] tc,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear ? '0 : cnt + W'(1);
  assign done = (cnt == tc);
endmodule

// File: rtl/pic_reset_ctrl.sv
// pic_reset_ctrl: OST/PWRT/WDT reset sequencer and TO_n status for the PIC16F84 core.
// Define PIC_PWRT_EN to build the power-up timer phase; otherwise OST goes straight to RUN.
module pic_reset_ctrl
  import pic_rst_pkg::*;
#(
  parameter int OST_CYCLES      = OST_CYCLES_DEF,
  parameter int PWRT_CYCLES     = PWRT_CYCLES_DEF,
  parameter int WDT_HOLD_CYCLES = WDT_HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwrte,
  input  logic       wdt_timeout,
  input  logic       clrwdt,
  output logic       core_reset,
  output logic       to_n,
  output logic [2:0] state
);
  localparam int CNT_W = cnt_width(OST_CYCLES, PWRT_CYCLES, WDT_HOLD_CYCLES);
  logic [2:0]       next;
  logic [CNT_W-1:0] tc;
  logic             done, clear, go_pwrt, core_reset_d, to_n_d;
  assign tc = (state == PWRT) ? CNT_W'(PWRT_CYCLES - 1) :
              (state == WDT)  ? CNT_W'(WDT_HOLD_CYCLES - 1) : CNT_W'(OST_CYCLES - 1);
  // Held at zero outside timed phases so it can never wrap.
  assign clear = (next != state) || (state == HOLD) || (state == RUN);
  pic_rst_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tc    (tc),
    .done  (done)
  );
`ifdef PIC_PWRT_EN
  logic pwrte_q;
  // Dropped on watchdog entry so the restart after a time-out skips PWRT.
  always_ff @(posedge clk or posedge reset)
    if (reset) pwrte_q <= 1'b0;
    else if (state == HOLD) pwrte_q <= pwrte;
    else if (next == WDT) pwrte_q <= 1'b0;
  assign go_pwrt = pwrte_q;
`else
  logic unused_pwrte;
  assign unused_pwrte = pwrte;
  assign go_pwrt = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= HOLD;
      core_reset <= 1'b1;
      to_n       <= 1'b1;
    end else begin
      state      <= next;
      core_reset <= core_reset_d;
      to_n       <= to_n_d;
    end
  always_comb begin
    next = HOLD;
    case (state)
      HOLD: next = OST;
      OST:  next = done ? (go_pwrt ? PWRT : RUN) : OST;
`ifdef PIC_PWRT_EN
      PWRT: next = done ? RUN : PWRT;
`endif
      RUN:  next = wdt_timeout ? WDT : RUN;
      WDT:  next = done ? OST : WDT;
      default: next = HOLD;
    endcase
  end
  always_comb begin
    core_reset_d = (next != RUN);
    to_n_d = (state == RUN && wdt_timeout) ? 1'b0 :
             (state == RUN && clrwdt) ? 1'b1 : to_n;
  end
endmodule

// File: tb/tb_pic_reset_ctrl.sv
// tb_pic_reset_ctrl: scoreboard bench; stimulus queues expected output changes
// (edge, state, core_reset, to_n), a negedge monitor pops one per observed change.
module tb_pic_reset_ctrl;
  localparam logic [2:0] S_HOLD = 3'd0, S_OST = 3'd1, S_PWRT = 3'd2, S_RUN = 3'd3, S_WDT = 3'd4;
`ifdef PIC_PWRT_EN
  localparam bit PWRT_ON = 1'b1;
`else
  localparam bit PWRT_ON = 1'b0;
`endif
  typedef struct {
    int         e;
    logic [2:0] st;
    logic       cr;
    logic       tn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pwrte = 1'b1;
  logic       wdt_timeout = 1'b0;
  logic       clrwdt = 1'b0;
  logic       core_reset, to_n;
  logic [2:0] state;

  pic_reset_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pwrte       (pwrte),
    .wdt_timeout (wdt_timeout),
    .clrwdt      (clrwdt),
    .core_reset  (core_reset),
    .to_n        (to_n),
    .state       (state)
  );

  always #5 clk = ~clk;

  int    edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  exp_t  q[$];
  string phase = "reset";
  int    total = 0, bad = 0;
  int    req_n = 0, done_n = 0;
  int    rel, k;
  bit    first = 1'b1;
  logic [4:0] prev;

  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t x;
    cur = {state, core_reset, to_n};
    if (first || cur !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL %s unexpected change edge=%0d got st=%0d cr=%0b tn=%0b want no change",
                 phase, edge_n, state, core_reset, to_n);
      end else begin
        x = q.pop_front();
        if (cur !== {x.st, x.cr, x.tn} || (x.e >= 0 && x.e != edge_n)) begin
          bad++;
          $display("FAIL %s edge=%0d st=%0d cr=%0b tn=%0b want edge=%0d st=%0d cr=%0b tn=%0b",
                   phase, edge_n, state, core_reset, to_n, x.e, x.st, x.cr, x.tn);
        end
      end
      prev  = cur;
      first = 1'b0;
    end
    if (req_n != done_n) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL %s pending expectations got=%0d want=0 next edge=%0d st=%0d",
                 phase, q.size(), q[0].e, q[0].st);
      end
      done_n = req_n;
    end
  end

  task automatic push(input int e, input logic [2:0] st, input logic cr, input logic tn);
    exp_t x;
    x.e = e; x.st = st; x.cr = cr; x.tn = tn;
    q.push_back(x);
  endtask

  task automatic check_empty();
    req_n++;
    repeat (2) @(negedge clk);
  endtask

  task automatic boot(input bit pw);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel = edge_n;
    push(rel + 1, S_OST, 1'b1, 1'b1);
    if (pw && PWRT_ON) begin
      push(rel + 1025, S_PWRT, 1'b1, 1'b1);
      push(rel + 5121, S_RUN, 1'b0, 1'b1);
    end else push(rel + 1025, S_RUN, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    push(edge_n, S_HOLD, 1'b1, 1'b1);
  endtask

  initial begin
    push(-1, S_HOLD, 1'b1, 1'b1);
    #1 reset = 1'b1;
    phase = "boot_pwrte1";
    boot(1'b1);
    repeat (5131) @(negedge clk);
    check_empty();

    phase = "wdt_in_run";
    wdt_timeout = 1'b1;
    k = edge_n + 1;
    push(k, S_WDT, 1'b1, 1'b0);
    push(k + 4, S_OST, 1'b1, 1'b0);
    push(k + 1028, S_RUN, 1'b0, 1'b0);
    @(negedge clk) wdt_timeout = 1'b0;
    repeat (1040) @(negedge clk);
    check_empty();

    phase = "clrwdt_in_run";
    clrwdt = 1'b1;
    push(edge_n + 1, S_RUN, 1'b0, 1'b1);
    @(negedge clk) clrwdt = 1'b0;
    repeat (3) @(negedge clk);
    check_empty();

    phase = "wdt_and_clrwdt";
    wdt_timeout = 1'b1;
    clrwdt = 1'b1;
    k = edge_n + 1;
    push(k, S_WDT, 1'b1, 1'b0);
    push(k + 4, S_OST, 1'b1, 1'b0);
    push(k + 1028, S_RUN, 1'b0, 1'b0);
    @(negedge clk);
    wdt_timeout = 1'b0;
    clrwdt = 1'b0;
    repeat (20) @(negedge clk);
    phase = "pulses_in_ost";
    wdt_timeout = 1'b1;
    @(negedge clk) wdt_timeout = 1'b0;
    clrwdt = 1'b1;
    @(negedge clk) clrwdt = 1'b0;
    repeat (1020) @(negedge clk);
    check_empty();

    phase = "boot_pwrte0";
    async_reset();
    pwrte = 1'b0;
    boot(1'b0);
    repeat (1035) @(negedge clk);
    check_empty();

    phase = "reset_mid_pwrt";
    async_reset();
    pwrte = 1'b1;
    boot(1'b1);
    repeat (3025) @(posedge clk);
    #1 reset = 1'b1;
    push(edge_n, S_HOLD, 1'b1, 1'b1);
    phase = "reboot_pwrte1";
    boot(1'b1);
    repeat (5131) @(negedge clk);
    check_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pic_reset_ctrl.md
# pic_reset_ctrl

Reset sequencer between the bench/board clock-and-reset source and the PIC16F84-compatible core. It turns the raw asynchronous reset into a clean, timed core reset by modelling the oscillator start-up timer (OST) and power-up timer (PWRT). It also re-sequences the core after a watchdog time-out and maintains the TO_n status bit the core reports in STATUS.

## Interface
- OST_CYCLES, 1024: clock cycles spent in the oscillator start-up phase; must be at least 1.
- PWRT_CYCLES, 4096: clock cycles spent in the power-up timer phase; must be at least 1.
- WDT_HOLD_CYCLES, 4: cycles core_reset is held in the WDT phase before OST restarts; must be at least 1.
- CNT_W, derived: $clog2 of the largest of the three counts plus 1; not overridden.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset (external MCLR / power-on).
- pwrte  in  1  configuration-word PWRTE bit; 1 enables the PWRT phase; sampled only on the HOLD→OST edge.
- wdt_timeout  in  1  one-cycle pulse from the watchdog.
- clrwdt  in  1  one-cycle pulse, core executed CLRWDT or SLEEP.
- core_reset  out  1  registered, active-high reset to the core.
- to_n  out  1  time-out status bit, active-low.
- state  out  3  current FSM state, for debug/bench.

## Operation
- FSM states:
  - HOLD: entered by reset.
  - OST: start-up timer running.
  - PWRT: power-up timer running.
  - RUN: core released.
  - WDT: watchdog reset in progress.
- core_reset = (state != RUN), registered. It is never combinational from the inputs.
- HOLD→OST: on the first rising edge with reset low. Counter loads 0 and pwrte is captured into pwrte_q.
- OST→PWRT: when the counter reaches OST_CYCLES-1 and pwrte_q=1.
- OST→RUN: when the counter reaches OST_CYCLES-1 and pwrte_q=0.
- PWRT→RUN: when the counter reaches PWRT_CYCLES-1.
- Counter clears on every state change.
- RUN→WDT: on a wdt_timeout pulse. The same edge clears to_n to 0.
- WDT→OST: after WDT_HOLD_CYCLES cycles. The PWRT phase is skipped after a watchdog reset.
- wdt_timeout is ignored in every state except RUN.
- clrwdt in RUN sets to_n to 1. clrwdt in any other state is ignored.
- wdt_timeout and clrwdt on the same edge in RUN: the watchdog wins, to_n=0 and state goes to WDT.
- to_n is set to 1 only by reset or by clrwdt in RUN.

## Timing
- Reset values:
  - state = HOLD (3'd0)
  - core_reset = 1
  - to_n = 1
  - counter = 0
  - pwrte_q = 0
- Reset assertion is asynchronous: the reset values appear immediately, from any state and mid-count.
- Reset release, numbering edge 1 as the first rising edge with reset low:
  - core_reset falls on edge 1+OST_CYCLES+PWRT_CYCLES when pwrte=1.
  - core_reset falls on edge 1+OST_CYCLES when pwrte=0.
- Watchdog pulse sampled on edge k in RUN:
  - core_reset rises on edge k.
  - core_reset falls on edge k+WDT_HOLD_CYCLES+OST_CYCLES.
- Encodings: HOLD=0, OST=1, PWRT=2, RUN=3, WDT=4. Values 5 to 7 are illegal and recover to HOLD on the next edge.
- Counter arithmetic: unsigned, CNT_W bits. It never wraps, because the terminal-count compare always forces a state change first.

## Configuration
- PIC_PWRT_EN defined: PWRT state and pwrte_q are built; behaviour is as described above.
- PIC_PWRT_EN undefined:
  - The PWRT state is not built and OST goes straight to RUN.
  - The pwrte port still exists but is ignored.
  - Encoding 2 is treated as illegal.
  - Release happens on edge 1+OST_CYCLES regardless of pwrte.

## Structure
- Shared package pic_rst_pkg holds:
  - the state encoding localparams (HOLD, OST, PWRT, RUN, WDT);
  - the default values of OST_CYCLES, PWRT_CYCLES and WDT_HOLD_CYCLES;
  - the CNT_W derivation function.
- One sub-module: pic_rst_timer, a CNT_W-bit up-counter.
  - Inputs: clear, terminal-count value.
  - Output: a done flag.
  - Instantiated once and shared across the OST, PWRT and WDT phases.

## Test plan
- Power-on with pwrte=1 and defaults: release reset, then core_reset falls on edge 5121; state sequence is 0→1→2→3; to_n=1.
- Power-on with pwrte=0: core_reset falls on edge 1025; no cycle with state=2 is ever observed.
- Watchdog pulse in RUN at edge k:
  - core_reset=1 from edge k;
  - to_n=0;
  - state goes 4→1→3;
  - core_reset falls on edge k+1028;
  - a following clrwdt pulse restores to_n=1.
- Simultaneous wdt_timeout and clrwdt in RUN: to_n=0 and state=4. A wdt_timeout pulse during OST leaves state and to_n unchanged.
- Reset asserted mid-PWRT (counter at 2000): core_reset=1, state=0 and to_n=1 immediately. After re-release, the full 5121-edge sequence restarts from zero.
- Build without PIC_PWRT_EN, pwrte=1: core_reset falls on edge 1025.
